// File: rtl/vending_pkg.sv
// Shared types and constants for the vending transaction controller.
// Holds the state encoding, default prices and the money width.
package vending_pkg;

    localparam int MONEY_W    = 8;
    localparam int DEF_PRICE0 = 3;
    localparam int DEF_PRICE1 = 4;
    localparam int DEF_PRICE2 = 5;
    localparam int DEF_PRICE3 = 6;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_SELECT        = 3'd1,
        S_RECEIVE_MONEY = 3'd2,
        S_COMPARE       = 3'd3,
        S_PROCESS       = 3'd4,
        S_RETURN_CHANGE = 3'd5
    } state_t;

endpackage

// File: rtl/vending_fsm.sv
// Transaction state register and next-state logic.
// Ports: clk, reset_n, i_start, i_cancel, i_done_money, i_continue_buy,
//        i_out_stock, i_enough_money -> o_state (registered state).
module vending_fsm
    import vending_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_start,
    input  logic   i_cancel,
    input  logic   i_done_money,
    input  logic   i_continue_buy,
    input  logic   i_out_stock,
    input  logic   i_enough_money,
    output state_t o_state
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                w_next = i_start ? S_SELECT : S_IDLE;
            end
            S_SELECT: begin
                if (i_cancel)
                    w_next = S_IDLE;
                else if (i_out_stock)
                    w_next = S_SELECT;
                else
                    w_next = S_RECEIVE_MONEY;
            end
            S_RECEIVE_MONEY: begin
                w_next = i_done_money ? S_COMPARE : S_RECEIVE_MONEY;
            end
            S_COMPARE: begin
                w_next = i_enough_money ? S_RETURN_CHANGE : S_PROCESS;
            end
            S_PROCESS: begin
                w_next = i_cancel ? S_RETURN_CHANGE : S_RECEIVE_MONEY;
            end
            S_RETURN_CHANGE: begin
                w_next = i_continue_buy ? S_SELECT : S_IDLE;
            end
            // Unused codes 6 and 7 recover to IDLE.
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/vending_control.sv
// Vending transaction controller: sum accumulator, item latch, stock.
// Ports: clk, reset_n, start, cancel, item_in, money, done_money,
//        continue_buy -> done, end_trans, sum_money, price, item_select, state.
module vending_control
    import vending_pkg::*;
#(
    parameter int INIT_STOCK = 3,
    parameter int PRICE0     = DEF_PRICE0,
    parameter int PRICE1     = DEF_PRICE1,
    parameter int PRICE2     = DEF_PRICE2,
    parameter int PRICE3     = DEF_PRICE3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               cancel,
    input  logic [1:0]         item_in,
    input  logic [2:0]         money,
    input  logic               done_money,
    input  logic               continue_buy,
    output logic               done,
    output logic               end_trans,
    output logic [MONEY_W-1:0] sum_money,
    output logic [MONEY_W-1:0] price,
    output logic [1:0]         item_select,
    output logic [2:0]         state
);

    localparam int W_CLOG  = $clog2(INIT_STOCK + 1);
    localparam int STOCK_W = (W_CLOG > 2) ? W_CLOG : 2;

    state_t               w_state;
    logic [MONEY_W-1:0]   r_sum;
    logic [1:0]           r_item;
    logic                 r_bought;
    logic [STOCK_W-1:0]   r_stock [4];

    logic                 w_out_stock;
    logic                 w_enough;
    logic [MONEY_W-1:0]   w_price;
    logic [MONEY_W:0]     w_sum_add;
    logic [MONEY_W-1:0]   w_sum_sat;

    vending_fsm u_fsm (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (start),
        .i_cancel       (cancel),
        .i_done_money   (done_money),
        .i_continue_buy (continue_buy),
        .i_out_stock    (w_out_stock),
        .i_enough_money (w_enough),
        .o_state        (w_state)
    );

    always_comb begin
        w_price = '0;
        case (r_item)
            2'd0: w_price = MONEY_W'(PRICE0);
            2'd1: w_price = MONEY_W'(PRICE1);
            2'd2: w_price = MONEY_W'(PRICE2);
            default: w_price = MONEY_W'(PRICE3);
        endcase
    end

    // Stock check uses the live keypad code, not the latched one.
    assign w_out_stock = (r_stock[item_in] == '0);
    assign w_enough    = (r_sum >= w_price);

    // One extra bit catches the carry; a carry pins the sum at full scale.
    assign w_sum_add = {1'b0, r_sum} + (MONEY_W + 1)'(money);
    assign w_sum_sat = w_sum_add[MONEY_W] ? '1 : w_sum_add[MONEY_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum    <= '0;
            r_item   <= '0;
            r_bought <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            case (w_state)
                S_SELECT: begin
                    r_item <= item_in;
                end
                S_RECEIVE_MONEY: begin
                    r_sum <= w_sum_sat;
                end
                S_COMPARE: begin
                    // Leaving SELECT required stock, so this never wraps.
                    if (w_enough) begin
                        r_bought        <= 1'b1;
                        r_stock[r_item] <= r_stock[r_item] - 1'b1;
                    end
                end
                S_RETURN_CHANGE: begin
                    r_sum    <= '0;
                    r_bought <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        done        = 1'b0;
        end_trans   = 1'b0;
        sum_money   = '0;
        price       = '0;
        item_select = '0;
        if (w_state == S_RETURN_CHANGE) begin
            end_trans = 1'b1;
            sum_money = r_sum;
            done      = r_bought;
            if (r_bought) begin
                price       = w_price;
                item_select = r_item;
            end
        end
    end

    assign state = w_state;

endmodule

// File: tb/tb_vending_control.sv
// Scoreboard bench for vending_control: stimulus queues expectations,
// a monitor pops and compares them on the falling clock edge.
module tb_vending_control;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       cancel;
    logic [1:0] item_in;
    logic [2:0] money;
    logic       done_money;
    logic       continue_buy;
    logic       done;
    logic       end_trans;
    logic [7:0] sum_money;
    logic [7:0] price;
    logic [1:0] item_select;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       d;
        logic       e;
        logic [7:0] s;
        logic [7:0] p;
        logic [1:0] it;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    event chk_now;

    vending_control dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cancel       (cancel),
        .item_in      (item_in),
        .money        (money),
        .done_money   (done_money),
        .continue_buy (continue_buy),
        .done         (done),
        .end_trans    (end_trans),
        .sum_money    (sum_money),
        .price        (price),
        .item_select  (item_select),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        start        = 1'b0;
        cancel       = 1'b0;
        item_in      = 2'd0;
        money        = 3'd0;
        done_money   = 1'b0;
        continue_buy = 1'b0;
    endtask

    task automatic push(input logic [2:0] st, input logic d,
                        input logic e, input logic [7:0] s,
                        input logic [7:0] p, input logic [1:0] it);
        exp_t x;
        x.st = st;
        x.d  = d;
        x.e  = e;
        x.s  = s;
        x.p  = p;
        x.it = it;
        q.push_back(x);
    endtask

    task automatic tick(input logic [2:0] st, input logic d,
                        input logic e, input logic [7:0] s,
                        input logic [7:0] p, input logic [1:0] it);
        @(posedge clk);
        #1;
        push(st, d, e, s, p, it);
        clr();
    endtask

    task automatic tq(input logic [2:0] st);
        tick(st, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
    endtask

    // Monitor: compare the oldest expectation with the live outputs.
    initial begin
        exp_t x;
        exp_t a;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() != 0) begin
                x = q.pop_front();
                a.st = state;
                a.d  = done;
                a.e  = end_trans;
                a.s  = sum_money;
                a.p  = price;
                a.it = item_select;
                checks++;
                if (a !== x) begin
                    failures++;
                    $display("FAIL chk%0d st=%0d d=%b e=%b sum=%0d pr=%0d it=%0d expected st=%0d d=%b e=%b sum=%0d pr=%0d it=%0d",
                             checks, a.st, a.d, a.e, a.s, a.p, a.it,
                             x.st, x.d, x.e, x.s, x.p, x.it);
                end
            end else if (end_trans === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL unexpected_end_trans st=%0d sum=%0d expected no end_trans",
                         state, sum_money);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        clr();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        push(3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
        @(negedge clk);
        #1;

        // Idle hold, start, cancel in SELECT.
        tq(3'd0);
        start = 1'b1;
        tq(3'd1);
        cancel = 1'b1;
        tq(3'd0);
        start = 1'b1;
        tq(3'd1);
        item_in = 2'd1;
        tq(3'd2);
        money = 3'd1; done_money = 1'b1;
        tq(3'd3);
        tq(3'd4);
        cancel = 1'b1;
        tick(3'd5, 1'b0, 1'b1, 8'd1, 8'd0, 2'd0);
        tq(3'd0);

        // Item 0: underpay twice, then refund.
        start = 1'b1;
        tq(3'd1);
        item_in = 2'd0;
        tq(3'd2);
        money = 3'd1; done_money = 1'b1;
        tq(3'd3);
        tq(3'd4);
        tq(3'd2);
        money = 3'd1; done_money = 1'b1;
        tq(3'd3);
        tq(3'd4);
        cancel = 1'b1;
        tick(3'd5, 1'b0, 1'b1, 8'd2, 8'd0, 2'd0);
        continue_buy = 1'b1;
        tq(3'd1);

        // Item 1: coins 4 then 2; cancel/start ignored mid-transaction.
        item_in = 2'd1;
        tq(3'd2);
        money = 3'd4; cancel = 1'b1;
        tq(3'd2);
        money = 3'd2; done_money = 1'b1;
        tq(3'd3);
        start = 1'b1; cancel = 1'b1;
        tick(3'd5, 1'b1, 1'b1, 8'd6, 8'd4, 2'd1);
        tq(3'd0);

        // Drain item 3.
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            tq(3'd1);
            item_in = 2'd3;
            tq(3'd2);
            money = 3'd6; done_money = 1'b1;
            tq(3'd3);
            tick(3'd5, 1'b1, 1'b1, 8'd6, 8'd6, 2'd3);
            tq(3'd0);
        end
        start = 1'b1;
        tq(3'd1);
        item_in = 2'd3;
        tq(3'd1);
        item_in = 2'd3;
        tq(3'd1);

        // Item 2 with sum saturation: 38 coins of 7 exceed 255.
        item_in = 2'd2;
        tq(3'd2);
        for (int k = 0; k < 37; k++) begin
            money = 3'd7;
            tq(3'd2);
        end
        money = 3'd7; done_money = 1'b1;
        tq(3'd3);
        tick(3'd5, 1'b1, 1'b1, 8'd255, 8'd5, 2'd2);
        tq(3'd0);

        // Reset restores stock of item 3.
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        start = 1'b1;
        tq(3'd1);
        item_in = 2'd3;
        tq(3'd2);
        money = 3'd5;
        tq(3'd2);

        // Asynchronous reset with sum=5 in RECEIVE_MONEY.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        push(3'd0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
        ->chk_now;
        #1;
        reset_n = 1'b1;

        // Sum must be cleared: zero-coin refund reports 0.
        start = 1'b1;
        tq(3'd1);
        item_in = 2'd0;
        tq(3'd2);
        done_money = 1'b1;
        tq(3'd3);
        tq(3'd4);
        cancel = 1'b1;
        tick(3'd5, 1'b0, 1'b1, 8'd0, 8'd0, 2'd0);
        tq(3'd0);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_control.md
# vending_control

Vending-machine transaction controller. Sequences one purchase: start, item selection with stock check, coin accumulation, price compare, optional top-up or cancel, then a change/dispense report. It sits between the coin/keypad front end and the dispenser/change logic, and it keeps per-item stock counts internally.

## Interface
Parameters:
- `INIT_STOCK`, default 3: units of each item after reset.
- `PRICE0`..`PRICE3`, defaults 3, 4, 5, 6: item prices in money units.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a transaction.
- `cancel`, in, 1: abort; honoured in SELECT and PROCESS only.
- `item_in`, in, 2: requested item code.
- `money`, in, 3: coin value, unsigned, added each RECEIVE_MONEY cycle.
- `done_money`, in, 1: customer has finished inserting coins.
- `continue_buy`, in, 1: in RETURN_CHANGE, start another purchase.
- `done`, out, 1: item dispensed (purchase succeeded).
- `end_trans`, out, 1: transaction ends this cycle.
- `sum_money`, out, 8: total inserted, shown in RETURN_CHANGE.
- `price`, out, 8: price of the purchased item.
- `item_select`, out, 2: purchased item code.
- `state`, out, 3: current state register.

## Operation
State encoding: IDLE=0, SELECT=1, RECEIVE_MONEY=2, COMPARE=3, PROCESS=4, RETURN_CHANGE=5. Codes 6 and 7 go to IDLE.

Transitions:
- IDLE: `start` → SELECT; otherwise stay.
- SELECT: `cancel` → IDLE (cancel has priority). Otherwise `out_stock` → stay. Otherwise → RECEIVE_MONEY.
  - Latch `item_in` every SELECT cycle.
- RECEIVE_MONEY: add `money` to the sum every cycle, including the cycle where `done_money`=1. `done_money` → COMPARE; otherwise stay.
- COMPARE: `enough_money` → RETURN_CHANGE with purchase flag set; otherwise → PROCESS.
- PROCESS (insufficient funds): `cancel` → RETURN_CHANGE with purchase flag clear (refund). Otherwise → RECEIVE_MONEY; the sum is kept.
- RETURN_CHANGE: `continue_buy` → SELECT; otherwise → IDLE. Clear the sum and the purchase flag on exit.

Internal signals:
- `out_stock` = (stock[item_in] == 0), combinational from the live `item_in`.
- `enough_money` = (sum ≥ price of the latched item).
- Change value = sum − price. It is internal and not an output.

Arithmetic and stock:
- Sum is 8-bit unsigned and saturates at 255.
- Stock counters are 2 bits wide minimum, sized to hold `INIT_STOCK`.
- Decrement stock of the latched item on the COMPARE→RETURN_CHANGE transition when the purchase flag is set.

Outputs:
- All outputs are Moore, decoded from registered state.
- In RETURN_CHANGE:
  - `end_trans`=1.
  - `sum_money`=sum.
  - `done`=purchase flag.
  - `price` and `item_select` show the latched item's values when the purchase flag is set, else 0.
- In every other state, `done`, `end_trans`, `sum_money`, `price` and `item_select` are all 0.

## Timing
- Reset (asynchronous):
  - state=IDLE; sum=0; latched item=0; purchase flag=0; all stock=`INIT_STOCK`.
  - All outputs 0.
  - Reset in the middle of a transaction discards it; stock is restored.
- One state transition per rising edge. Inputs are sampled at the edge.
- Fastest purchase after `start` is seen in IDLE: SELECT +1, RECEIVE_MONEY +2, COMPARE +3 (a single coin with `done_money`), RETURN_CHANGE +4. Outputs are valid during the RETURN_CHANGE cycle.
- RETURN_CHANGE lasts exactly one cycle.
- `cancel` in RECEIVE_MONEY, COMPARE or RETURN_CHANGE is ignored.
- `start` outside IDLE is ignored.

## Structure
- Package `vending_pkg`:
  - state enum (3-bit) with the codes above;
  - default price constants;
  - the money width constant (8).
- Sub-module `vending_fsm`: state register plus next-state logic. It takes `out_stock`, `enough_money`, `cancel`, `start`, `done_money` and `continue_buy`.
- The top level holds:
  - the sum accumulator;
  - the item latch and purchase flag;
  - the price lookup;
  - the stock array;
  - output decode.

## Test plan
- Reset, then `start`=0 for one clock → state=0, all outputs 0. Then `start`=1 → state=1 one edge later, outputs still 0.
- IDLE→SELECT with `cancel`=1 → state=0 one edge later. With `cancel`=0 and `item_in`=1 in stock → state=2.
- `item_in`=0: money 1 plus `done_money` → COMPARE, then 1<3 → PROCESS. Then `cancel`=0 → RECEIVE_MONEY; `cancel`=1 → RETURN_CHANGE with `done`=0, `end_trans`=1, `sum_money`=1.
- `item_in`=1: money 4 then 2 with `done_money` on the second coin → COMPARE, then RETURN_CHANGE.
  - Outputs: `done`=1, `end_trans`=1, `sum_money`=6, `price`=4, `item_select`=1.
  - `continue_buy`=0 → IDLE; `continue_buy`=1 → SELECT with outputs 0.
- Three successful purchases of item 3 (price 6) → the next SELECT with `item_in`=3 holds in SELECT (out of stock). Reset restores stock.
- Assert reset while in RECEIVE_MONEY with sum=5 → state=0 and `sum_money`=0 immediately, before the next clock edge.
